// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the instruction-fetch / data-port RAM arbiter.
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2,
    ERR      = 2'd3
  } arb_state_t;

  // Which port owns (or last owned) the RAM
  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grant_t;

  // Access size encodings; 2'b11 is treated as a word everywhere
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Width of the wait counter, enough for latencies up to 15
  localparam int unsigned CNT_W = 4;

  // Natural alignment rule: bytes anywhere, halves on even, words on multiples of 4
  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment checker for the access about to be granted.
module mem_align_check
  import mem_arb_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] size,
  output logic       misaligned
);

  // Pure decode of the low address bits against the access size
  always_comb begin
    misaligned = is_misaligned(addr_lo, size);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency RAM between an instruction
// fetch port and a load/store port. Each grant latches the access so the RAM
// sees stable controls while the requester's inputs may wander.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  // data port
  input  logic        mem_req,
  input  logic        mem_rw,
  input  logic        mem_se,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_stall,
  output logic        align_err,
  // shared RAM
  output logic        ram_en,
  output logic        ram_rw,
  output logic        ram_se,
  output logic [1:0]  ram_size,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  // The counter runs WAIT_CYCLES-1 .. 0 across the busy cycles, so the final
  // busy cycle (count 0) is the completion cycle.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t       state;
  grant_t           last_grant;
  logic [CNT_W-1:0] wait_cnt;

  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_size;
  logic        lat_rw;
  logic        lat_se;

  logic        grant_vld;
  grant_t      grant_sel;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic        misaligned;

  logic busy;
  logic if_done;
  logic mem_done;

  // Pick the next owner while idle; ties go to the port that did not win last
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = GNT_IF;
    if (state == IDLE) begin
      grant_vld = if_req | mem_req;
      if (if_req && mem_req) begin
        grant_sel = (last_grant == GNT_IF) ? GNT_MEM : GNT_IF;
      end else if (mem_req) begin
        grant_sel = GNT_MEM;
      end
    end
    sel_addr = (grant_sel == GNT_MEM) ? mem_addr : if_addr;
    sel_size = (grant_sel == GNT_MEM) ? mem_size : SZ_WORD;
  end

  mem_align_check u_align (
    .addr_lo    (sel_addr[1:0]),
    .size       (sel_size),
    .misaligned (misaligned)
  );

  // Arbiter FSM: grant from IDLE, count down in BUSY, one-cycle ERR response
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      last_grant <= GNT_IF;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            last_grant <= grant_sel;
            wait_cnt   <= WAIT_LOAD;
            if (misaligned) begin
              state <= ERR;
            end else if (grant_sel == GNT_MEM) begin
              state <= BUSY_MEM;
            end else begin
              state <= BUSY_IF;
            end
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (wait_cnt == '0) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ERR: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Capture the winning access; the RAM is driven only from these copies
  always_ff @(posedge clk) begin
    if (grant_vld) begin
      lat_addr  <= sel_addr;
      lat_size  <= sel_size;
      lat_rw    <= (grant_sel == GNT_MEM) ? mem_rw    : 1'b0;
      lat_se    <= (grant_sel == GNT_MEM) ? mem_se    : 1'b0;
      lat_wdata <= (grant_sel == GNT_MEM) ? mem_wdata : 32'h0;
    end
  end

  // Port and RAM outputs decoded from the registered state
  always_comb begin
    busy     = (state == BUSY_IF) || (state == BUSY_MEM);
    if_done  = (state == BUSY_IF)  && (wait_cnt == '0);
    mem_done = (state == BUSY_MEM) && (wait_cnt == '0);

    if_ready  = if_done  || ((state == ERR) && (last_grant == GNT_IF));
    mem_ready = mem_done || ((state == ERR) && (last_grant == GNT_MEM));
    align_err = (state == ERR);

    // Error responses return zero data; only a real completion passes RAM data
    if_rdata  = if_done  ? ram_rdata : 32'h0;
    mem_rdata = mem_done ? ram_rdata : 32'h0;

    if_stall  = if_req  & ~if_ready;
    mem_stall = mem_req & ~mem_ready;

    ram_en    = busy;
    ram_addr  = busy ? lat_addr  : 32'h0;
    ram_wdata = busy ? lat_wdata : 32'h0;
    ram_size  = busy ? lat_size  : 2'b00;
    ram_rw    = busy ? lat_rw    : 1'b0;
    ram_se    = busy ? lat_se    : 1'b0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter (latency 2 main instance, latency 1 side instance).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main DUT, WAIT_CYCLES = 2
  logic        if_req, mem_req, mem_rw, mem_se;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [1:0]  mem_size;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_ready, if_stall, mem_ready, mem_stall, align_err;
  logic        ram_en, ram_rw, ram_se;
  logic [1:0]  ram_size;

  // side DUT, WAIT_CYCLES = 1
  logic        if_req1, mem_req1, mem_rw1, mem_se1;
  logic [31:0] if_addr1, mem_addr1, mem_wdata1, ram_rdata1;
  logic [1:0]  mem_size1;
  logic [31:0] if_rdata1, mem_rdata1, ram_addr1, ram_wdata1;
  logic        if_ready1, if_stall1, mem_ready1, mem_stall1, align_err1;
  logic        ram_en1, ram_rw1, ram_se1;
  logic [1:0]  ram_size1;

  mem_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_se(mem_se), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
    .align_err(align_err), .ram_en(ram_en), .ram_rw(ram_rw), .ram_se(ram_se), .ram_size(ram_size),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1), .if_stall(if_stall1),
    .mem_req(mem_req1), .mem_rw(mem_rw1), .mem_se(mem_se1), .mem_size(mem_size1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .mem_ready(mem_ready1), .mem_stall(mem_stall1),
    .align_err(align_err1), .ram_en(ram_en1), .ram_rw(ram_rw1), .ram_se(ram_se1), .ram_size(ram_size1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        port;   // 1 = data port, 0 = fetch port
    logic [31:0] rdata;
    logic        err;
    int          at;     // cycle in which the ready pulse must appear
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic push(input logic port, input logic [31:0] rdata, input logic err, input int at);
    exp_t x;
    x.port  = port;
    x.rdata = rdata;
    x.err   = err;
    x.at    = at;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ready pulse of the main DUT must match the oldest expectation
  always @(negedge clk) begin
    if (if_ready || mem_ready) begin
      chk("one_ready", {31'b0, if_ready & mem_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", {31'b0, mem_ready}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("rdy_port",  {31'b0, mem_ready}, {31'b0, e.port});
        chk("rdy_rdata", mem_ready ? mem_rdata : if_rdata, e.rdata);
        chk("rdy_align", {31'b0, align_err}, {31'b0, e.err});
        chk("rdy_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Hard stop in case the sequence itself wedges
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int c0;
  int s0;
  logic mem_busy_k, if_busy_k;

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = 0; mem_req = 0; mem_rw = 0; mem_se = 0; mem_size = SZ_WORD;
    mem_addr = 0; mem_wdata = 0; ram_rdata = 0;
    if_req1 = 0; if_addr1 = 0; mem_req1 = 0; mem_rw1 = 0; mem_se1 = 0; mem_size1 = SZ_WORD;
    mem_addr1 = 0; mem_wdata1 = 0; ram_rdata1 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ram_en",   {31'b0, ram_en},    32'd0);
    chk("rst_if_ready", {31'b0, if_ready},  32'd0);
    chk("rst_mem_rdy",  {31'b0, mem_ready}, 32'd0);
    chk("rst_align",    {31'b0, align_err}, 32'd0);
    chk("rst_ram_addr", ram_addr,           32'd0);
    chk("rst_ram_en1",  {31'b0, ram_en1},   32'd0);
    tick();
    reset = 1'b0;

    // Word load at 0x10
    tick();
    c0 = cyc;
    mem_req = 1; mem_rw = 0; mem_size = SZ_WORD; mem_addr = 32'h10; ram_rdata = 32'hDEADBEEF;
    push(1'b1, 32'hDEADBEEF, 1'b0, c0 + 2);
    @(negedge clk);
    chk("lw_stall_c",  {31'b0, mem_stall}, 32'd1);
    chk("lw_en_c",     {31'b0, ram_en},    32'd0);
    @(negedge clk);
    chk("lw_en_c1",    {31'b0, ram_en},    32'd1);
    chk("lw_addr_c1",  ram_addr,           32'h10);
    chk("lw_size_c1",  {30'b0, ram_size},  {30'b0, SZ_WORD});
    chk("lw_rw_c1",    {31'b0, ram_rw},    32'd0);
    chk("lw_stall_c1", {31'b0, mem_stall}, 32'd1);
    @(negedge clk);
    chk("lw_en_c2",    {31'b0, ram_en},    32'd1);
    chk("lw_rdy_c2",   {31'b0, mem_ready}, 32'd1);
    chk("lw_stall_c2", {31'b0, mem_stall}, 32'd0);
    tick();
    mem_req = 0;
    @(negedge clk);
    chk("lw_en_after",   {31'b0, ram_en}, 32'd0);
    chk("lw_addr_after", ram_addr,        32'd0);
    chk("lw_rdata_idle", mem_rdata,       32'd0);

    // Word store at 0x10 with the address/data changed mid-access
    tick();
    c0 = cyc;
    mem_req = 1; mem_rw = 1; mem_size = SZ_WORD; mem_addr = 32'h10; mem_wdata = 32'hCAFEF00D;
    ram_rdata = 32'h12345678;
    push(1'b1, 32'h12345678, 1'b0, c0 + 2);
    tick();
    mem_addr = 32'h40; mem_wdata = 32'h0BADF00D;
    @(negedge clk);
    chk("sw_addr_c1",  ram_addr,        32'h10);
    chk("sw_wdata_c1", ram_wdata,       32'hCAFEF00D);
    chk("sw_rw_c1",    {31'b0, ram_rw}, 32'd1);
    @(negedge clk);
    chk("sw_addr_c2",  ram_addr,        32'h10);
    tick();
    mem_req = 0; mem_rw = 0;

    // Misaligned word store at 0x22 -> error response, RAM untouched
    tick();
    c0 = cyc;
    mem_req = 1; mem_rw = 1; mem_size = SZ_WORD; mem_addr = 32'h22; mem_wdata = 32'h1111;
    push(1'b1, 32'h0, 1'b1, c0 + 1);
    @(negedge clk);
    chk("swmis_en_c",  {31'b0, ram_en},    32'd0);
    @(negedge clk);
    chk("swmis_en_c1", {31'b0, ram_en},    32'd0);
    chk("swmis_err",   {31'b0, align_err}, 32'd1);
    tick();
    mem_req = 0;
    @(negedge clk);
    chk("swmis_err_after", {31'b0, align_err}, 32'd0);

    // Half store at 0x22 is aligned
    tick();
    c0 = cyc;
    mem_req = 1; mem_rw = 1; mem_size = SZ_HALF; mem_addr = 32'h22; mem_wdata = 32'h0000ABCD;
    ram_rdata = 32'h55AA55AA;
    push(1'b1, 32'h55AA55AA, 1'b0, c0 + 2);
    @(negedge clk);
    @(negedge clk);
    chk("sh_en",    {31'b0, ram_en},   32'd1);
    chk("sh_size",  {30'b0, ram_size}, {30'b0, SZ_HALF});
    chk("sh_addr",  ram_addr,          32'h22);
    chk("sh_wdata", ram_wdata,         32'h0000ABCD);
    @(negedge clk);
    chk("sh_align", {31'b0, align_err}, 32'd0);
    tick();
    mem_req = 0; mem_rw = 0;

    // Misaligned fetch at 0x6 -> fetch error response
    tick();
    c0 = cyc;
    if_req = 1; if_addr = 32'h6;
    push(1'b0, 32'h0, 1'b1, c0 + 1);
    @(negedge clk);
    chk("ifmis_stall_c",  {31'b0, if_stall}, 32'd1);
    @(negedge clk);
    chk("ifmis_en_c1",    {31'b0, ram_en},   32'd0);
    chk("ifmis_stall_c1", {31'b0, if_stall}, 32'd0);
    tick();
    if_req = 0;

    // Signed byte load at odd address 0x23
    tick();
    c0 = cyc;
    mem_req = 1; mem_rw = 0; mem_se = 1; mem_size = SZ_BYTE; mem_addr = 32'h23;
    ram_rdata = 32'hFFFF_FF80;
    push(1'b1, 32'hFFFF_FF80, 1'b0, c0 + 2);
    @(negedge clk);
    @(negedge clk);
    chk("lb_se",   {31'b0, ram_se},   32'd1);
    chk("lb_size", {30'b0, ram_size}, {30'b0, SZ_BYTE});
    chk("lb_addr", ram_addr,          32'h23);
    @(negedge clk);
    tick();
    mem_req = 0; mem_se = 0;

    // Reset in the first busy cycle of a store, then reset held over a grant opportunity
    tick();
    mem_req = 1; mem_rw = 1; mem_size = SZ_WORD; mem_addr = 32'h30; mem_wdata = 32'h77;
    tick();
    reset = 1; if_req = 1; if_addr = 32'h8;
    @(negedge clk);
    chk("rstw_en_busy", {31'b0, ram_en}, 32'd1);
    chk("rstw_rw_busy", {31'b0, ram_rw}, 32'd1);
    tick();
    @(negedge clk);
    chk("rstw_en_next",  {31'b0, ram_en},    32'd0);
    chk("rstw_no_ready", {31'b0, mem_ready}, 32'd0);
    chk("rstw_stall",    {31'b0, mem_stall}, 32'd1);
    tick();
    reset = 0;
    s0 = cyc;
    ram_rdata = 32'h0F0F1234;

    // Both requests held: MEM first (last_grant reset to IF), then alternate
    push(1'b1, 32'h0F0F1234, 1'b0, s0 + 2);
    push(1'b0, 32'h0F0F1234, 1'b0, s0 + 5);
    push(1'b1, 32'h0F0F1234, 1'b0, s0 + 8);
    push(1'b0, 32'h0F0F1234, 1'b0, s0 + 11);
    for (int k = 0; k < 12; k++) begin
      mem_busy_k = (k == 1) || (k == 2) || (k == 7) || (k == 8);
      if_busy_k  = (k == 4) || (k == 5) || (k == 10) || (k == 11);
      @(negedge clk);
      chk($sformatf("rr_mstall_%0d", k), {31'b0, mem_stall}, (k == 2 || k == 8)  ? 32'd0 : 32'd1);
      chk($sformatf("rr_istall_%0d", k), {31'b0, if_stall},  (k == 5 || k == 11) ? 32'd0 : 32'd1);
      chk($sformatf("rr_en_%0d", k), {31'b0, ram_en}, (mem_busy_k || if_busy_k) ? 32'd1 : 32'd0);
      if (mem_busy_k) chk($sformatf("rr_maddr_%0d", k), ram_addr, 32'h30);
      if (if_busy_k)  chk($sformatf("rr_iaddr_%0d", k), ram_addr, 32'h8);
    end
    tick();
    if_req = 0; mem_req = 0; mem_rw = 0;
    @(negedge clk);
    chk("rr_en_end", {31'b0, ram_en}, 32'd0);

    // Latency-1 instance: fetch at 0x4
    tick();
    if_req1 = 1; if_addr1 = 32'h4; ram_rdata1 = 32'hA5A50004;
    @(negedge clk);
    chk("w1_stall_c",  {31'b0, if_stall1}, 32'd1);
    chk("w1_ready_c",  {31'b0, if_ready1}, 32'd0);
    chk("w1_en_c",     {31'b0, ram_en1},   32'd0);
    @(negedge clk);
    chk("w1_ready_c1", {31'b0, if_ready1}, 32'd1);
    chk("w1_rdata_c1", if_rdata1,          32'hA5A50004);
    chk("w1_stall_c1", {31'b0, if_stall1}, 32'd0);
    chk("w1_en_c1",    {31'b0, ram_en1},   32'd1);
    chk("w1_addr_c1",  ram_addr1,          32'h4);
    tick();
    if_req1 = 0;
    @(negedge clk);
    chk("w1_ready_c2", {31'b0, if_ready1},  32'd0);
    chk("w1_en_c2",    {31'b0, ram_en1},    32'd0);
    chk("w1_rdata_c2", if_rdata1,           32'd0);
    chk("w1_mem_side", {31'b0, mem_ready1 | mem_stall1 | align_err1 | ram_rw1 | ram_se1}, 32'd0);
    chk("w1_mem_data", mem_rdata1 | ram_wdata1 | {30'b0, ram_size1}, 32'd0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
